// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared definitions for the FFT input loader: default sample width,
//   default frame-size exponent and the loader state encoding.
package fft_pkg;

  localparam int WIDTH = 16;  // signed bits per real/imag part
  localparam int N     = 9;   // frame holds 2**N complex samples

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    BURST = 2'd2
  } state_t;

endpackage

// File: rtl/inram.sv
// inram
//   Single-port 2**depth_log2 x width buffer RAM. Synchronous write,
//   registered read with one cycle of latency. Contents are never reset.
// Ports:
//   clka   clock
//   addra  shared read/write address
//   dina   write data
//   wea    write enable
//   douta  read data, valid the cycle after addra is presented
module inram #(
  parameter int width      = 16,
  parameter int depth_log2 = 9
) (
  input  logic                  clka,
  input  logic [depth_log2-1:0] addra,
  input  logic [width-1:0]      dina,
  input  logic                  wea,
  output logic [width-1:0]      douta
);

  logic [width-1:0] mem_r [0:(2**depth_log2)-1];

  // Storage write and registered read port.
  always_ff @(posedge clka) begin
    if (wea) begin
      mem_r[addra] <= dina;
    end else begin
      mem_r[addra] <= mem_r[addra];
    end
    douta <= mem_r[addra];
  end

endmodule

// File: rtl/fft_loader.sv
// fft_loader
//   Collects one frame of 2**N complex samples from a strobed input into a
//   pair of buffer RAMs, then streams the whole frame out in natural order as
//   one uninterrupted burst once the downstream FFT is ready.
// Ports:
//   clk        single clock, all state on its rising edge
//   areset     asynchronous active-high reset
//   din_valid  input sample strobe (din_re/din_im valid this cycle)
//   din_re     signed input sample, real part
//   din_im     signed input sample, imaginary part
//   fft_ready  downstream can accept a new frame
//   en_fft     high for exactly 2**N consecutive cycles per burst
//   cnt_fft    sample index aligned with dout_re/dout_im (0 when idle)
//   dout_re    burst data, real part
//   dout_im    burst data, imaginary part
//   busy       high while a full frame is held or being streamed
//   ovf        sticky: an input sample was dropped
module fft_loader #(
  parameter int width = fft_pkg::WIDTH,
  parameter int N     = fft_pkg::N
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             din_valid,
  input  logic [width-1:0] din_re,
  input  logic [width-1:0] din_im,
  input  logic             fft_ready,
  output logic             en_fft,
  output logic [N-1:0]     cnt_fft,
  output logic [width-1:0] dout_re,
  output logic [width-1:0] dout_im,
  output logic             busy,
  output logic             ovf
);

  import fft_pkg::state_t;
  import fft_pkg::FILL;
  import fft_pkg::FULL;
  import fft_pkg::BURST;

  localparam logic [N-1:0] LAST_ADDR = {N{1'b1}};
  localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};

  state_t         state_r;
  logic [N-1:0]   wr_cnt_r;
  logic [N-1:0]   rd_addr_r;
  logic [N-1:0]   ram_addr_s;
  logic           ram_we_s;

  // The RAMs are single-port: writes own the address in FILL, reads in BURST,
  // so a read and a write can never collide.
  assign ram_addr_s = (state_r == BURST) ? rd_addr_r : wr_cnt_r;
  assign ram_we_s   = (state_r == FILL) && din_valid;

  // Loader FSM, address counters and all registered outputs.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r   <= FILL;
      wr_cnt_r  <= '0;
      rd_addr_r <= '0;
      en_fft    <= 1'b0;
      cnt_fft   <= '0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (din_valid) begin
            // wr_cnt wraps to 0 on the last write, ready for the next frame.
            wr_cnt_r <= wr_cnt_r + ONE;
            if (wr_cnt_r == LAST_ADDR) begin
              state_r <= FULL;
              busy    <= 1'b1;
            end else begin
              state_r <= FILL;
              busy    <= 1'b0;
            end
          end else begin
            state_r <= FILL;
            busy    <= 1'b0;
          end
        end
        FULL: begin
          busy <= 1'b1;
          if (fft_ready) begin
            state_r <= BURST;
          end else begin
            state_r <= FULL;
          end
        end
        BURST: begin
          // fft_ready is deliberately ignored here: a burst never stalls.
          rd_addr_r <= rd_addr_r + ONE;
          if (rd_addr_r == LAST_ADDR) begin
            state_r <= FILL;
            busy    <= 1'b0;
          end else begin
            state_r <= BURST;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r   <= FILL;
          rd_addr_r <= '0;
          busy      <= 1'b0;
        end
      endcase

      // Enable and index follow the read address by one cycle to line up
      // with the RAM's registered read data.
      en_fft  <= (state_r == BURST);
      cnt_fft <= (state_r == BURST) ? rd_addr_r : '0;

      if (din_valid && (state_r != FILL)) begin
        ovf <= 1'b1;
      end else begin
        ovf <= ovf;
      end
    end
  end

  inram #(.width(width), .depth_log2(N)) u_ram_re (
    .clka  (clk),
    .addra (ram_addr_s),
    .dina  (din_re),
    .wea   (ram_we_s),
    .douta (dout_re)
  );

  inram #(.width(width), .depth_log2(N)) u_ram_im (
    .clka  (clk),
    .addra (ram_addr_s),
    .dina  (din_im),
    .wea   (ram_we_s),
    .douta (dout_im)
  );

endmodule

// File: tb/tb_fft_loader.sv
`timescale 1ns/1ps
module tb_fft_loader;

  localparam int W     = 16;
  localparam int NB    = 9;
  localparam int FRAME = 512;

  typedef struct {
    int           idx;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          din_valid = 1'b0;
  logic [W-1:0]  din_re = '0;
  logic [W-1:0]  din_im = '0;
  logic          fft_ready = 1'b0;
  logic          en_fft;
  logic [NB-1:0] cnt_fft;
  logic [W-1:0]  dout_re;
  logic [W-1:0]  dout_im;
  logic          busy;
  logic          ovf;

  int checks = 0;
  int failures = 0;

  always #12.5 clk = ~clk;

  fft_loader #(.width(W), .N(NB)) dut (
    .clk       (clk),
    .areset    (areset),
    .din_valid (din_valid),
    .din_re    (din_re),
    .din_im    (din_im),
    .fft_ready (fft_ready),
    .en_fft    (en_fft),
    .cnt_fft   (cnt_fft),
    .dout_re   (dout_re),
    .dout_im   (dout_im),
    .busy      (busy),
    .ovf       (ovf)
  );

  // Scoreboard: every burst sample is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (areset !== 1'b1) begin
      if (en_fft === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_empty: burst sample cnt_fft=%0d re=%0d with no expected entry", cnt_fft, dout_re);
        end else begin
          mon_e = sb.pop_front();
          if (cnt_fft !== mon_e.idx[NB-1:0] || dout_re !== mon_e.re || dout_im !== mon_e.im) begin
            failures++;
            $display("FAIL sb_data: got cnt=%0d re=%h im=%h expected cnt=%0d re=%h im=%h",
                     cnt_fft, dout_re, dout_im, mon_e.idx, mon_e.re, mon_e.im);
          end
        end
      end else begin
        checks++;
        if (cnt_fft !== '0) begin
          failures++;
          $display("FAIL cnt_idle: cnt_fft=%0d while en_fft=%b, expected 0", cnt_fft, en_fft);
        end
      end
    end
  end

  task automatic push(input int idx, input logic [W-1:0] re, input logic [W-1:0] im);
    exp_t e;
    e.idx = idx;
    e.re  = re;
    e.im  = im;
    sb.push_back(e);
  endtask

  // Drives one full frame re = base+i, im = -(base+i); all samples expected back.
  task automatic feed_frame(input int base);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din_re    = W'(base + i);
      din_im    = W'(-(base + i));
      push(i, din_re, din_im);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Waits (bounded) for en_fft, then counts its consecutive high cycles.
  task automatic wait_burst(output int en_cycles, output int last_cnt, output bit timeout);
    en_cycles = 0;
    last_cnt  = -1;
    timeout   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (en_fft === 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
    if (!timeout) begin
      while (en_fft === 1'b1 && en_cycles < 600) begin
        en_cycles++;
        last_cnt = int'(cnt_fft);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    din_valid = 1'b0;
    fft_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (en_fft !== 1'b0) begin failures++; $display("FAIL reset_en_fft got=%b exp=0", en_fft); end
    checks++; if (cnt_fft !== '0) begin failures++; $display("FAIL reset_cnt_fft got=%0d exp=0", cnt_fft); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    areset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int n, last;
    bit to;
    fft_ready = 1'b1;
    feed_frame(0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_full got=%b exp=1", busy); end
    wait_burst(n, last, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++; if (n != FRAME) begin failures++; $display("FAIL basic_en_len got=%0d exp=%0d", n, FRAME); end
    checks++; if (last != FRAME - 1) begin failures++; $display("FAIL basic_last_cnt got=%0d exp=%0d", last, FRAME - 1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL basic_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_hold();
    int n, last, bad;
    bit to;
    fft_ready = 1'b0;
    feed_frame(1000);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || en_fft !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_busy_noen bad_cycles got=%0d exp=0", bad); end
    fft_ready = 1'b1;
    @(negedge clk);
    checks++; if (en_fft !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL hold_start1 got en=%b busy=%b exp en=0 busy=1", en_fft, busy); end
    @(negedge clk);
    checks++; if (en_fft !== 1'b1 || cnt_fft !== '0) begin failures++; $display("FAIL hold_start2 got en=%b cnt=%0d exp en=1 cnt=0", en_fft, cnt_fft); end
    wait_burst(n, last, to);
    checks++; if (to || n != FRAME - 1 || last != FRAME - 1) begin failures++; $display("FAIL hold_rest got n=%0d last=%0d to=%b exp n=%0d last=%0d", n, last, to, FRAME - 1, FRAME - 1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_ovf();
    int n, last;
    bit to;
    fft_ready = 1'b0;
    feed_frame(2000);
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b exp=0", ovf); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din_re = 16'h7FFF;
      din_im = 16'h8000;
    end
    @(negedge clk);
    din_valid = 1'b0;
    fft_ready = 1'b1;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", ovf); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din_re = 16'h1234;
      din_im = 16'h4321;
    end
    @(negedge clk);
    din_valid = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_burst got=%b exp=1", ovf); end
    wait_burst(n, last, to);
    checks++; if (to || last != FRAME - 1) begin failures++; $display("FAIL ovf_burst_end got last=%0d to=%b exp last=%0d", last, to, FRAME - 1); end
    feed_frame(3000);
    wait_burst(n, last, to);
    checks++; if (to || n != FRAME) begin failures++; $display("FAIL ovf_next_len got=%0d to=%b exp=%0d", n, to, FRAME); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL ovf_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_ready_drop();
    int n, last;
    bit seen;
    fft_ready = 1'b1;
    feed_frame(4000);
    n = 0; last = -1; seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (en_fft === 1'b1) begin
        seen = 1'b1;
        n++;
        last = int'(cnt_fft);
        if (cnt_fft == 9'd100) fft_ready = 1'b0;
      end else if (seen) begin
        break;
      end
    end
    checks++; if (!seen || n != FRAME) begin failures++; $display("FAIL drop_len got=%0d seen=%b exp=%0d", n, seen, FRAME); end
    checks++; if (last != FRAME - 1) begin failures++; $display("FAIL drop_last got=%0d exp=%0d", last, FRAME - 1); end
  endtask

  task automatic test_reset_mid();
    int n, last;
    bit to, hit;
    fft_ready = 1'b1;
    feed_frame(5000);
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (en_fft === 1'b1 && cnt_fft == 9'd200) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach got=0 exp=1"); end
    #1 areset = 1'b1;
    #1;
    checks++; if (en_fft !== 1'b0 || cnt_fft !== '0) begin failures++; $display("FAIL rstmid_trunc got en=%b cnt=%0d exp en=0 cnt=0", en_fft, cnt_fft); end
    checks++; if (busy !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL rstmid_flags got busy=%b ovf=%b exp 0 0", busy, ovf); end
    sb.delete();
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    checks++; if (en_fft !== 1'b0) begin failures++; $display("FAIL rstmid_partial got en=%b exp=0", en_fft); end
    feed_frame(6000);
    wait_burst(n, last, to);
    checks++; if (to || n != FRAME || last != FRAME - 1) begin failures++; $display("FAIL rstmid_fresh got n=%0d last=%0d to=%b exp n=%0d last=%0d", n, last, to, FRAME, FRAME - 1); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rstmid_sb_left got=%0d exp=0", sb.size()); end
  endtask

  // din_valid every cycle: samples 0..511 form frame 1; 512 (FULL) and
  // 513..1024 (BURST) are dropped; 1025 arrives on FILL re-entry -> index 0.
  task automatic test_back_to_back();
    int n, last;
    bit to;
    fft_ready = 1'b1;
    for (int c = 0; c < 1537; c++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din_re = W'(c);
      din_im = W'(-c);
      if (c < FRAME) push(c, din_re, din_im);
      else if (c >= 1025) push(c - 1025, din_re, din_im);
    end
    @(negedge clk);
    din_valid = 1'b0;
    wait_burst(n, last, to);
    checks++; if (to || n != FRAME || last != FRAME - 1) begin failures++; $display("FAIL b2b_len got n=%0d last=%0d to=%b exp n=%0d last=%0d", n, last, to, FRAME, FRAME - 1); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL b2b_ovf got=%b exp=1", ovf); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_sb_left got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_ovf();
    test_ready_drop();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
